// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: steers each accepted bit into the lane
// given by an internal counter and hands completed frames out on valid/ready.
module tdm_demux #(
    parameter  int N  = 4,
    localparam int LW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sync,
    output logic [N-1:0]  out_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] lane,
    output logic          frame_err
);

    localparam logic [LW-1:0] LAST = LW'(N - 1);

    logic [LW-1:0] eff_lane;
    logic [LW-1:0] lane_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  out_word_nxt;
    logic          out_valid_nxt;
    logic          frame_err_nxt;
    logic          accept;
    logic          load;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            acc       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            lane      <= lane_nxt;
            acc       <= acc_nxt;
            out_word  <= out_word_nxt;
            out_valid <= out_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Next-state logic; a drain and a load in the same cycle keep out_valid high
    always_comb begin
        lane_nxt      = lane;
        acc_nxt       = acc;
        out_word_nxt  = out_word;
        out_valid_nxt = out_valid;
        frame_err_nxt = sync && (lane != '0);

        if (accept) begin
            acc_nxt[eff_lane] = in_bit;
            lane_nxt = (eff_lane == LAST) ? '0 : eff_lane + LW'(1);
        end else if (sync) begin
            lane_nxt = '0;
        end

        if (load) begin
            out_word_nxt  = acc_nxt;
            out_valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // Handshake outputs; only the completing bit can stall on a full output register
    always_comb begin
        eff_lane = sync ? '0 : lane;
        in_ready = (eff_lane != LAST) || !out_valid || out_ready;
        accept   = in_valid && in_ready;
        load     = accept && (eff_lane == LAST);
    end

endmodule
